// File: rtl/wavepool_instr_issue.sv
// Wavepool instruction issue: per-wavefront instruction queues, base-register table,
// and a round-robin selector that drives the registered wave_* bundle toward decode.
module wavepool_instr_issue #(
  parameter int NUM_WF = 40,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [5:0]        fetch_wfid,
  input  logic [31:0]       fetch_instr,
  input  logic [31:0]       fetch_pc,
  input  logic              dispatch_valid,
  input  logic [5:0]        dispatch_wfid,
  input  logic [9:0]        dispatch_vgpr_base,
  input  logic [8:0]        dispatch_sgpr_base,
  input  logic [15:0]       dispatch_lds_base,
  input  logic [NUM_WF-1:0] wf_stall,
  input  logic              flopped_issue_recover_en,
  input  logic [5:0]        flopped_issue_recover_wfid,
  output logic              wave_instr_valid,
  output logic [31:0]       wave_instr_pc,
  output logic [31:0]       wave_instr,
  output logic [5:0]        wave_wfid,
  output logic [9:0]        wave_vgpr_base,
  output logic [8:0]        wave_sgpr_base,
  output logic [15:0]       wave_lds_base,
  output logic [NUM_WF-1:0] wf_buf_full,
  output logic [NUM_WF-1:0] wf_buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   r_mem    [NUM_WF][DEPTH];
  logic [PW-1:0] r_rd_ptr [NUM_WF];
  logic [PW-1:0] r_wr_ptr [NUM_WF];
  logic [CW-1:0] r_cnt    [NUM_WF];
  logic [9:0]    r_vgpr   [NUM_WF];
  logic [8:0]    r_sgpr   [NUM_WF];
  logic [15:0]   r_lds    [NUM_WF];
  logic [5:0]    r_rr_ptr;

  logic          r_valid;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [5:0]    r_wfid;
  logic [9:0]    r_vgpr_out;
  logic [8:0]    r_sgpr_out;
  logic [15:0]   r_lds_out;

  logic [NUM_WF-1:0] w_flush;
  logic [NUM_WF-1:0] w_push;
  logic [NUM_WF-1:0] w_elig;
  logic [NUM_WF-1:0] w_hi_mask;
  logic [NUM_WF-1:0] w_pop;
  logic              w_grant;
  logic [5:0]        w_gnt_id;

  // Lowest set bit index; positions past the last slot are never set.
  function automatic logic [5:0] first_set(input logic [NUM_WF-1:0] v);
    logic [5:0] r;
    logic       found;
    r     = 6'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_WF; i++) begin
      r     = (!found && v[i]) ? 6'(i) : r;
      found = found | v[i];
    end
    return r;
  endfunction

  // Per-slot flush, push acceptance, eligibility and queue status
  always_comb begin
    w_flush      = '0;
    w_push       = '0;
    w_elig       = '0;
    w_hi_mask    = '0;
    wf_buf_full  = '0;
    wf_buf_empty = '0;
    for (int w = 0; w < NUM_WF; w++) begin
      w_flush[w]      = (flopped_issue_recover_en && (flopped_issue_recover_wfid == 6'(w))) ||
                        (dispatch_valid && (dispatch_wfid == 6'(w)));
      wf_buf_full[w]  = (r_cnt[w] == FULL_CNT);
      wf_buf_empty[w] = (r_cnt[w] == '0);
      // Full is judged before any same-cycle pop, so a full queue drops the push.
      w_push[w]       = fetch_valid && (fetch_wfid == 6'(w)) && !wf_buf_full[w] && !w_flush[w];
      w_elig[w]       = !wf_buf_empty[w] && !wf_stall[w] && !w_flush[w];
      w_hi_mask[w]    = w_elig[w] && (6'(w) >= r_rr_ptr);
    end
  end

  // Round-robin grant: first eligible at or above the pointer, else wrap to the lowest
  always_comb begin
    w_grant  = |w_elig;
    w_gnt_id = (|w_hi_mask) ? first_set(w_hi_mask) : first_set(w_elig);
    w_pop    = '0;
    for (int w = 0; w < NUM_WF; w++) begin
      w_pop[w] = w_grant && (w_gnt_id == 6'(w));
    end
  end

  // Queue state, base table, round-robin pointer and the registered issue bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WF; w++) begin
        r_cnt[w]    <= '0;
        r_rd_ptr[w] <= '0;
        r_wr_ptr[w] <= '0;
        r_vgpr[w]   <= 10'd0;
        r_sgpr[w]   <= 9'd0;
        r_lds[w]    <= 16'd0;
      end
      r_rr_ptr   <= 6'd0;
      r_valid    <= 1'b0;
      r_pc       <= 32'd0;
      r_instr    <= 32'd0;
      r_wfid     <= 6'd0;
      r_vgpr_out <= 10'd0;
      r_sgpr_out <= 9'd0;
      r_lds_out  <= 16'd0;
    end else begin
      for (int w = 0; w < NUM_WF; w++) begin
        if (w_flush[w]) begin
          r_cnt[w]    <= '0;
          r_rd_ptr[w] <= '0;
          r_wr_ptr[w] <= '0;
        end else begin
          if (w_push[w]) begin
            r_mem[w][r_wr_ptr[w]] <= {fetch_pc, fetch_instr};
            r_wr_ptr[w]           <= r_wr_ptr[w] + PW'(1);
          end
          if (w_pop[w]) begin
            r_rd_ptr[w] <= r_rd_ptr[w] + PW'(1);
          end
          case ({w_push[w], w_pop[w]})
            2'b10:   r_cnt[w] <= r_cnt[w] + CW'(1);
            2'b01:   r_cnt[w] <= r_cnt[w] - CW'(1);
            default: r_cnt[w] <= r_cnt[w];
          endcase
        end
        if (dispatch_valid && (dispatch_wfid == 6'(w))) begin
          r_vgpr[w] <= dispatch_vgpr_base;
          r_sgpr[w] <= dispatch_sgpr_base;
          r_lds[w]  <= dispatch_lds_base;
        end
        if (w_pop[w]) begin
          r_pc       <= r_mem[w][r_rd_ptr[w]][63:32];
          r_instr    <= r_mem[w][r_rd_ptr[w]][31:0];
          r_wfid     <= 6'(w);
          r_vgpr_out <= r_vgpr[w];
          r_sgpr_out <= r_sgpr[w];
          r_lds_out  <= r_lds[w];
        end
      end
      r_valid <= w_grant;
      if (w_grant) begin
        r_rr_ptr <= (w_gnt_id == 6'(NUM_WF - 1)) ? 6'd0 : w_gnt_id + 6'd1;
      end
    end
  end

  assign wave_instr_valid = r_valid;
  assign wave_instr_pc    = r_pc;
  assign wave_instr       = r_instr;
  assign wave_wfid        = r_wfid;
  assign wave_vgpr_base   = r_vgpr_out;
  assign wave_sgpr_base   = r_sgpr_out;
  assign wave_lds_base    = r_lds_out;

endmodule

// File: tb/tb_wavepool_instr_issue.sv
// Bench for wavepool_instr_issue: directed scenarios plus random traffic, checked by a
// queue-based reference model feeding a scoreboard that a negedge monitor drains.
module tb_wavepool_instr_issue;
  localparam int NUM_WF = 40;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_valid = 1'b0;
  logic [5:0]        fetch_wfid = 6'd0;
  logic [31:0]       fetch_instr = 32'd0;
  logic [31:0]       fetch_pc = 32'd0;
  logic              dispatch_valid = 1'b0;
  logic [5:0]        dispatch_wfid = 6'd0;
  logic [9:0]        dispatch_vgpr_base = 10'd0;
  logic [8:0]        dispatch_sgpr_base = 9'd0;
  logic [15:0]       dispatch_lds_base = 16'd0;
  logic [NUM_WF-1:0] wf_stall = '0;
  logic              rec_en = 1'b0;
  logic [5:0]        rec_wfid = 6'd0;
  logic              wave_instr_valid;
  logic [31:0]       wave_instr_pc;
  logic [31:0]       wave_instr;
  logic [5:0]        wave_wfid;
  logic [9:0]        wave_vgpr_base;
  logic [8:0]        wave_sgpr_base;
  logic [15:0]       wave_lds_base;
  logic [NUM_WF-1:0] wf_buf_full;
  logic [NUM_WF-1:0] wf_buf_empty;

  always #5 clk = ~clk;

  wavepool_instr_issue #(.NUM_WF(NUM_WF), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_wfid(fetch_wfid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .dispatch_valid(dispatch_valid), .dispatch_wfid(dispatch_wfid),
    .dispatch_vgpr_base(dispatch_vgpr_base), .dispatch_sgpr_base(dispatch_sgpr_base),
    .dispatch_lds_base(dispatch_lds_base), .wf_stall(wf_stall),
    .flopped_issue_recover_en(rec_en), .flopped_issue_recover_wfid(rec_wfid),
    .wave_instr_valid(wave_instr_valid), .wave_instr_pc(wave_instr_pc), .wave_instr(wave_instr),
    .wave_wfid(wave_wfid), .wave_vgpr_base(wave_vgpr_base), .wave_sgpr_base(wave_sgpr_base),
    .wave_lds_base(wave_lds_base), .wf_buf_full(wf_buf_full), .wf_buf_empty(wf_buf_empty)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  wfid;
    logic [9:0]  vgpr;
    logic [8:0]  sgpr;
    logic [15:0] lds;
  } bundle_t;

  typedef struct {
    bundle_t b;
    int      due;
  } exp_t;

  exp_t        exp_q[$];
  bundle_t     last_b = '0;
  logic [63:0] mq [NUM_WF][$];
  logic [9:0]  m_vgpr [NUM_WF];
  logic [8:0]  m_sgpr [NUM_WF];
  logic [15:0] m_lds  [NUM_WF];
  int          rr = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies one clock edge's worth of rules to plain queues.
  task automatic model_edge();
    bit          fl[NUM_WF];
    int          g;
    bit          push_ok;
    logic [63:0] head;
    exp_t        e;
    if (rst) begin
      for (int w = 0; w < NUM_WF; w++) begin
        mq[w].delete();
        m_vgpr[w] = 10'd0;
        m_sgpr[w] = 9'd0;
        m_lds[w]  = 16'd0;
      end
      rr     = 0;
      last_b = '0;
      return;
    end
    for (int w = 0; w < NUM_WF; w++) fl[w] = 1'b0;
    if (rec_en && int'(rec_wfid) < NUM_WF) fl[rec_wfid] = 1'b1;
    if (dispatch_valid && int'(dispatch_wfid) < NUM_WF) fl[dispatch_wfid] = 1'b1;
    g = -1;
    for (int k = 0; k < NUM_WF; k++) begin
      int w;
      w = (rr + k) % NUM_WF;
      if (g < 0 && mq[w].size() > 0 && !wf_stall[w] && !fl[w]) g = w;
    end
    push_ok = 1'b0;
    if (fetch_valid && int'(fetch_wfid) < NUM_WF)
      push_ok = !fl[fetch_wfid] && (mq[fetch_wfid].size() < DEPTH);
    if (g >= 0) begin
      head    = mq[g].pop_front();
      e.b     = {head[63:32], head[31:0], 6'(g), m_vgpr[g], m_sgpr[g], m_lds[g]};
      e.due   = cyc + 1;
      exp_q.push_back(e);
      rr = (g + 1) % NUM_WF;
    end
    if (push_ok) mq[fetch_wfid].push_back({fetch_pc, fetch_instr});
    for (int w = 0; w < NUM_WF; w++) if (fl[w]) mq[w].delete();
    if (dispatch_valid && int'(dispatch_wfid) < NUM_WF) begin
      m_vgpr[dispatch_wfid] = dispatch_vgpr_base;
      m_sgpr[dispatch_wfid] = dispatch_sgpr_base;
      m_lds[dispatch_wfid]  = dispatch_lds_base;
    end
  endtask

  // Monitor: compares queue status every cycle and pops the scoreboard on each issue
  always @(negedge clk) begin
    if (mon_en) begin
      logic [NUM_WF-1:0] ef, ee;
      bundle_t got;
      exp_t    e;
      for (int w = 0; w < NUM_WF; w++) begin
        ef[w] = (mq[w].size() == DEPTH);
        ee[w] = (mq[w].size() == 0);
      end
      check("buf_full", 128'(wf_buf_full), 128'(ef));
      check("buf_empty", 128'(wf_buf_empty), 128'(ee));
      got = {wave_instr_pc, wave_instr, wave_wfid, wave_vgpr_base, wave_sgpr_base, wave_lds_base};
      if (wave_instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 128'(got), 128'(0) - 128'(1));
        end else begin
          e = exp_q.pop_front();
          check("issue_cycle", 128'(cyc), 128'(e.due));
          check("issue_bundle", 128'(got), 128'(e.b));
          last_b = e.b;
        end
      end else begin
        if (exp_q.size() > 0) check("missing_issue_due", 128'(exp_q[0].due), 128'(cyc + 1000000));
        check("hold_bundle", 128'(got), 128'(last_b));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    fetch_valid    = 1'b0;
    dispatch_valid = 1'b0;
    rec_en         = 1'b0;
  endtask

  task automatic push(input int w, input logic [31:0] pc, input logic [31:0] ins);
    fetch_valid = 1'b1;
    fetch_wfid  = 6'(w);
    fetch_pc    = pc;
    fetch_instr = ins;
    step();
    clr();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single issue with dispatched bases
    dispatch_valid = 1'b1; dispatch_wfid = 6'd3;
    dispatch_vgpr_base = 10'h010; dispatch_sgpr_base = 9'h020; dispatch_lds_base = 16'h0100;
    step(); clr();
    push(3, 32'h100, 32'hBF81_0000);
    step();
    check("single_valid", 128'(wave_instr_valid), 128'(1));
    check("single_wfid", 128'(wave_wfid), 128'(3));
    check("single_pc", 128'(wave_instr_pc), 128'(32'h100));
    check("single_instr", 128'(wave_instr), 128'(32'hBF81_0000));
    check("single_vgpr", 128'(wave_vgpr_base), 128'(10'h010));
    check("single_sgpr", 128'(wave_sgpr_base), 128'(9'h020));
    check("single_lds", 128'(wave_lds_base), 128'(16'h0100));
    step();
    check("single_valid_drop", 128'(wave_instr_valid), 128'(0));

    // Round-robin across 0, 5, 39 then wrap
    wf_stall = '1;
    push(0, 32'h1000, 32'hA0); push(5, 32'h1005, 32'hA5); push(39, 32'h1039, 32'hA39);
    wf_stall = '0;
    idle(4);
    wf_stall = '1;
    push(0, 32'h2000, 32'hB0); push(5, 32'h2005, 32'hB5);
    wf_stall = '0;
    idle(3);

    // Stall holds wf 2 while wf 4 issues
    wf_stall = '1;
    push(2, 32'h3002, 32'hC2); push(4, 32'h3004, 32'hC4);
    wf_stall = '0; wf_stall[2] = 1'b1;
    idle(2);
    check("stall_hold_wf2", 128'(wf_buf_empty[2]), 128'(0));
    wf_stall = '0;
    idle(2);

    // Full queue drops third push
    wf_stall = '1;
    push(7, 32'h700, 32'hD0); push(7, 32'h704, 32'hD1); push(7, 32'h708, 32'hD2);
    check("full_wf7", 128'(wf_buf_full[7]), 128'(1));
    wf_stall = '0;
    idle(3);

    // Recover collides with a push to the same wavefront
    wf_stall = '1;
    push(9, 32'h900, 32'hE0); push(9, 32'h904, 32'hE1);
    rec_en = 1'b1; rec_wfid = 6'd9;
    push(9, 32'h200, 32'hE2);
    check("recover_empty_wf9", 128'(wf_buf_empty[9]), 128'(1));
    wf_stall = '0;
    idle(3);

    // Mid-run reset, then the search restarts at wf 0
    wf_stall = '1;
    push(1, 32'h501, 32'hF1); push(5, 32'h505, 32'hF5); push(20, 32'h520, 32'hF20);
    wf_stall = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_valid", 128'(wave_instr_valid), 128'(0));
    check("reset_pc", 128'(wave_instr_pc), 128'(0));
    check("reset_empty", 128'(wf_buf_empty), 128'({NUM_WF{1'b1}}));
    check("reset_full", 128'(wf_buf_full), 128'(0));
    wf_stall = '1;
    push(30, 32'h630, 32'h30); push(2, 32'h602, 32'h2);
    wf_stall = '0;
    step();
    check("post_reset_first_wfid", 128'(wave_wfid), 128'(2));
    idle(3);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      fetch_valid = ($urandom_range(0, 9) < 6);
      fetch_wfid  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 47)) : 6'($urandom_range(0, 7));
      fetch_pc    = $urandom;
      fetch_instr = $urandom;
      for (int w = 0; w < NUM_WF; w++) wf_stall[w] = ($urandom_range(0, 3) == 0);
      rec_en   = ($urandom_range(0, 19) == 0);
      rec_wfid = 6'($urandom_range(0, 43));
      dispatch_valid     = ($urandom_range(0, 19) == 0);
      dispatch_wfid      = 6'($urandom_range(0, 43));
      dispatch_vgpr_base = 10'($urandom);
      dispatch_sgpr_base = 9'($urandom);
      dispatch_lds_base  = 16'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    clr();
    wf_stall = '0;
    idle(100);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wavepool_instr_issue.md
Name: wavepool_instr_issue

Overview:
- Wavepool-side source of the wavepool-to-decode instruction stream.
- Buffers fetched instructions in a small queue per wavefront and holds a per-wavefront base-register table.
- Selects one ready wavefront per cycle round-robin and drives the registered wave_* bundle toward the decode pipeline flops.
- Consumes the flopped issue-recover pulse from the same interface to flush the named wavefront's queued instructions.

Parameters:
- NUM_WF, 40, number of wavefront slots; wfid width is fixed at 6.
- DEPTH, 2, instruction queue entries per wavefront (power of two, at least 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- fetch_valid  input  1  fetched instruction return valid
- fetch_wfid  input  6  wavefront of the returned instruction
- fetch_instr  input  32  instruction word
- fetch_pc  input  32  PC of the instruction word
- dispatch_valid  input  1  new wavefront allocated
- dispatch_wfid  input  6  slot being allocated
- dispatch_vgpr_base  input  10  VGPR base of the new wavefront
- dispatch_sgpr_base  input  9  SGPR base of the new wavefront
- dispatch_lds_base  input  16  LDS base of the new wavefront
- wf_stall  input  NUM_WF  per-wavefront stall mask from issue; 1 = do not select
- flopped_issue_recover_en  input  1  flush request
- flopped_issue_recover_wfid  input  6  wavefront to flush
- wave_instr_valid  output  1  instruction bundle valid
- wave_instr_pc  output  32  PC of the issued instruction
- wave_instr  output  32  issued instruction word
- wave_wfid  output  6  wfid of the issued instruction
- wave_vgpr_base  output  10  VGPR base of the issued wavefront
- wave_sgpr_base  output  9  SGPR base of the issued wavefront
- wave_lds_base  output  16  LDS base of the issued wavefront
- wf_buf_full  output  NUM_WF  per-wavefront queue full (combinational from counts)
- wf_buf_empty  output  NUM_WF  per-wavefront queue empty

Behaviour:
- Reset: all queues empty, so wf_buf_empty is all 1s and wf_buf_full is all 0s. Round-robin pointer = 0. Base table = 0. All wave_* outputs = 0.
- Queue write: when fetch_valid is high, {fetch_pc, fetch_instr} is pushed to queue[fetch_wfid].
  - If that queue is full, the push is dropped and the queue is unchanged. Fetch is required to check wf_buf_full.
- Eligibility: wavefront w is eligible when its queue is non-empty, wf_stall[w] = 0, and w is not being flushed this cycle (recover or dispatch of w).
- Arbitration: search starts at the round-robin pointer and wraps from NUM_WF-1 to 0; the first eligible w is granted.
  - On a grant, the pointer becomes w+1, wrapping to 0 at NUM_WF. With no grant, the pointer holds.
- Issue latency: 1 cycle. The head entry of the granted queue is popped at the grant edge.
  - On the next cycle, wave_instr_valid = 1 and wave_* carry the popped entry plus the table bases of that wfid.
  - With no grant, wave_instr_valid = 0 on the next cycle and the remaining wave_* hold their last values.
- Same-cycle push and pop on one queue are both performed; a full queue that is popped still drops the push, because full is evaluated before the pop.
- Recover: when flopped_issue_recover_en is high, queue[flopped_issue_recover_wfid] is emptied at that edge.
  - A same-cycle fetch push to that wfid is dropped as stale.
  - That wfid is not granted that cycle.
  - Other wavefronts are unaffected.
- Dispatch: when dispatch_valid is high, the base table entry for dispatch_wfid is written and its queue is emptied. The same stale-push and no-grant rules apply as for recover.
  - Bases written at edge N are visible in wave_* for grants at edge N+1 onward.
- Out-of-range wfid (>= NUM_WF) on fetch, dispatch or recover is ignored.
- Reset mid-operation: all state returns to its reset values at the next edge; in-flight entries are discarded.

Test Plan:
- Single issue: reset, dispatch wf 3 with vgpr 0x010, sgpr 0x020, lds 0x0100; push pc 0x100, instr 0xBF810000 to wf 3 -> one cycle after the grant, valid=1, wfid=3, pc=0x100, instr=0xBF810000, vgpr=0x010, sgpr=0x020, lds=0x0100; valid=0 on the following cycle.
- Round-robin fairness: one entry each in wf 0, 5 and 39, no stalls -> issue order 0, 5, 39. Then refill wf 0 and wf 5 -> pointer wraps and the order is 0, 5.
- Stall: wf 2 and wf 4 non-empty with wf_stall[2]=1 -> wf 4 issues and wf 2 holds. Clearing the stall -> wf 2 issues next.
- Full and drop: push 3 instructions to wf 7 with DEPTH=2, no grants -> wf_buf_full[7]=1 and the third push is lost. The two surviving entries then issue in FIFO order.
- Recover collision: wf 9 holds 2 entries; in one cycle assert recover for wf 9 and push pc 0x200 to wf 9 -> wf_buf_empty[9]=1, wf 9 never issues, and the 0x200 entry is absent.
- Mid-run reset: assert rst while 3 wavefronts hold entries -> next cycle all wave_* = 0, wf_buf_empty all 1s, and the first grant after reset starts the search at wf 0.
